// File: rtl/instr_sequencer_if.sv
// Signal bundle between the instruction sequencer and the instruction decoder / memory.
// The step_mode/step pair exists only when SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic              run;
  logic [15:0]       instr_in;
  logic [15:0]       ir;
  logic              fe;
  logic              e1;
  logic              e2;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;
`ifdef SINGLE_STEP_EN
  logic              step_mode;
  logic              step;

  modport master (
    input  run, instr_in, step_mode, step,
    output ir, fe, e1, e2, halted, instr_count
  );

  modport slave (
    output run, instr_in, step_mode, step,
    input  ir, fe, e1, e2, halted, instr_count
  );
`else
  modport master (
    input  run, instr_in,
    output ir, fe, e1, e2, halted, instr_count
  );

  modport slave (
    output run, instr_in,
    input  ir, fe, e1, e2, halted, instr_count
  );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute timing generator and instruction register feeding the decoder.
// Optional single-step support is compiled in with SINGLE_STEP_EN.
//
// state  | meaning
// HALT   | idle, waiting for run (or step); halted=1
// FETCH  | instruction memory word captured into ir; fe=1
// EXEC1  | first execute phase; decoder updates the PC; e1=1
// EXEC2  | second execute phase of memory-operand ops; e2=1
module instr_sequencer #(
  parameter bit AUTO_RUN = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC1 = 2'b10,
    S_EXEC2 = 2'b11
  } state_t;

  localparam state_t RST_STATE = AUTO_RUN ? S_FETCH : S_HALT;

  state_t             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         op;
  logic               two_phase;
  logic               go;
  state_t             retire_st;

  assign op = ir_q[15:11];

  // ADM 0001x, SBM 0011x, LDR 01110, LDA 110xx need a second execute cycle
  assign two_phase = (op[4:1] == 4'b0001) || (op[4:1] == 4'b0011) ||
                     (op == 5'b01110)     || (op[4:2] == 3'b110);

  always_comb begin
    go        = bus.run;
    retire_st = S_FETCH;
`ifdef SINGLE_STEP_EN
    go = bus.run | bus.step;
    if (bus.step_mode) retire_st = S_HALT;
`endif
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HALT: begin
        if (go) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = bus.instr_in;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (op == 5'b00000) begin
          state_d = S_HALT;
        end else if (two_phase) begin
          state_d = S_EXEC2;
        end else begin
          state_d = retire_st;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC2: begin
        state_d = retire_st;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      ir_q    <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded straight from the state register so reset drops e1/e2 immediately
  assign bus.fe          = (state_q == S_FETCH);
  assign bus.e1          = (state_q == S_EXEC1);
  assign bus.e2          = (state_q == S_EXEC2);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.ir          = ir_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected outputs, a monitor compares.
// The counter is built 8 bits wide so the wrap case fits a short run.
module tb_instr_sequencer;
  localparam int CW = 8;
  localparam logic [1:0] H = 2'b00, F = 2'b01, X1 = 2'b10, X2 = 2'b11;

  typedef struct {
    string          nm;
    logic [1:0]     st;
    logic [15:0]    ir;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic clk;
  logic reset;
  instr_sequencer_if #(.CNT_W(CW)) bus ();

  instr_sequencer #(.AUTO_RUN(1'b0), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t          q[$];
  exp_t          cur;
  event          mon_ev;
  int            n_checks = 0;
  int            n_err    = 0;
  logic [CW-1:0] exp_cnt  = '0;
  logic [3:0]    act_oh, exp_oh;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Monitor: compares once per cycle mid-period, or on demand for asynchronous events
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() > 0) begin
        cur    = q.pop_front();
        n_checks++;
        act_oh = {bus.fe, bus.e1, bus.e2, bus.halted};
        exp_oh = {cur.st == F, cur.st == X1, cur.st == X2, cur.st == H};
        if (act_oh !== exp_oh || bus.ir !== cur.ir || bus.instr_count !== cur.cnt) begin
          n_err++;
          $display("FAIL %s: got fe,e1,e2,halted=%b ir=%h cnt=%h; required %b ir=%h cnt=%h",
                   cur.nm, act_oh, bus.ir, bus.instr_count, exp_oh, cur.ir, cur.cnt);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [1:0] st, input logic [15:0] ir,
                      input logic [CW-1:0] cnt);
    exp_t e;
    e.nm = nm; e.st = st; e.ir = ir; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [1:0] st, input logic [15:0] ir,
                     input logic [CW-1:0] cnt);
    @(posedge clk);
    #1;
    push(nm, st, ir, cnt);
  endtask

  // Entered just after the DUT reaches FETCH; leaves just after the retire edge.
  task automatic do_instr(input string nm, input logic [15:0] w, input bit two,
                          input bit to_halt);
    bus.instr_in = w;
    cyc({nm, ".e1"}, X1, w, exp_cnt);
    bus.instr_in = 16'hFFFF;
    if (two) cyc({nm, ".e2"}, X2, w, exp_cnt);
    exp_cnt = exp_cnt + 1'b1;
    cyc({nm, ".ret"}, to_halt ? H : F, w, exp_cnt);
  endtask

  task automatic do_stp(input string nm);
    bus.instr_in = 16'h0000;
    cyc({nm, ".e1"}, X1, 16'h0000, exp_cnt);
    bus.instr_in = 16'hFFFF;
    cyc({nm, ".halt"}, H, 16'h0000, exp_cnt);
  endtask

  initial begin
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.instr_in = 16'hFFFF;
`ifdef SINGLE_STEP_EN
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
`endif
    cyc("reset_hold", H, 16'h0000, '0);
    reset = 1'b0;
    cyc("reset_rel", H, 16'h0000, '0);

    // single-phase ADR then LDA
    bus.run = 1'b1;
    cyc("run_fetch", F, 16'h0000, '0);
    bus.run = 1'b0;
    do_instr("adr5000", 16'h5000, 1'b0, 1'b0);
    do_instr("lda", 16'hC000, 1'b1, 1'b0);

    // two ADRs then STP, stay halted, resume
    do_instr("adr_a", 16'h5000, 1'b0, 1'b0);
    do_instr("adr_b", 16'h5000, 1'b0, 1'b0);
    do_stp("stp1");
    cyc("halt_stay", H, 16'h0000, exp_cnt);
    bus.run = 1'b1;
    cyc("resume", F, 16'h0000, exp_cnt);

    // run held high outside HALT is ignored; mix of phase classes
    do_instr("sbm", 16'h3000, 1'b1, 1'b0);
    do_instr("adm", 16'h1000, 1'b1, 1'b0);
    do_instr("ldr", 16'h7000, 1'b1, 1'b0);
    do_instr("op01111", 16'h7800, 1'b0, 1'b0);
    do_instr("op00100", 16'h2000, 1'b0, 1'b0);
    do_instr("op11100", 16'hE000, 1'b0, 1'b0);
    do_stp("stp_run");
    cyc("stp_run.fetch", F, 16'h0000, exp_cnt);
    bus.run = 1'b0;

    // reset during EXEC2 of SBM
    bus.instr_in = 16'h3000;
    cyc("sbm_rst.e1", X1, 16'h3000, exp_cnt);
    cyc("sbm_rst.e2", X2, 16'h3000, exp_cnt);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    push("async_reset", H, 16'h0000, '0);
    -> mon_ev;
    cyc("reset_held", H, 16'h0000, '0);
    reset = 1'b0;
    cyc("reset_rel2", H, 16'h0000, '0);

    // counter wrap: 256 retires on an 8-bit counter returns to zero
    bus.run = 1'b1;
    cyc("wrap_fetch", F, 16'h0000, exp_cnt);
    bus.run = 1'b0;
    for (int i = 0; i < 256; i++) begin
      case (i % 4)
        0: do_instr("wrap_adr", 16'h5000, 1'b0, 1'b0);
        1: do_instr("wrap_2000", 16'h2000, 1'b0, 1'b0);
        2: do_instr("wrap_e000", 16'hE000, 1'b0, 1'b0);
        default: do_instr("wrap_7800", 16'h7800, 1'b0, 1'b0);
      endcase
    end
    do_instr("post_wrap", 16'h5000, 1'b0, 1'b0);

`ifdef SINGLE_STEP_EN
    reset = 1'b1;
    cyc("ss_reset", H, 16'h0000, '0);
    reset   = 1'b0;
    exp_cnt = '0;
    bus.step_mode = 1'b1;
    bus.run       = 1'b1;
    cyc("ss_run", F, 16'h0000, exp_cnt);
    bus.run = 1'b0;
    do_instr("ss_adr", 16'h5000, 1'b0, 1'b1);
    cyc("ss_wait", H, 16'h5000, exp_cnt);
    bus.step = 1'b1;
    cyc("ss_step1", F, 16'h5000, exp_cnt);
    bus.step = 1'b0;
    do_instr("ss_adm", 16'h1000, 1'b1, 1'b1);
    cyc("ss_wait2", H, 16'h1000, exp_cnt);
    bus.step_mode = 1'b0;
    bus.step      = 1'b1;
    cyc("ss_step2", F, 16'h1000, exp_cnt);
    bus.step = 1'b0;
    do_instr("ss_free", 16'h5000, 1'b0, 1'b0);
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
